// File: rtl/real_mac_pkg.sv
// Shared types and helpers for the real-valued multiply-accumulate block.
package real_mac_pkg;

  // Control states of the accumulator sequencer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Fixed-point exponent of the accumulator: the exponent of a raw product.
  function automatic int acc_exp(input int a_exp, input int b_exp);
    return a_exp + b_exp;
  endfunction

endpackage

// File: rtl/real_mac_acc.sv
// Fixed-point dot-product engine: a registered multiplier stage feeds a
// wrapping accumulator with a sticky overflow flag. One product per cycle,
// valid/ready on both sides, result held until the consumer accepts it.
module real_mac_acc
  import real_mac_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int A_EXP     = -8,
  parameter int B_WIDTH   = 17,
  parameter int B_EXP     = -9,
  parameter int ACC_WIDTH = 40,
  parameter int LEN_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [LEN_WIDTH-1:0]        len_i,
  input  logic signed [A_WIDTH-1:0]   a_i,
  input  logic signed [B_WIDTH-1:0]   b_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic signed [ACC_WIDTH-1:0] acc_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        ovf_o,
  output logic                        busy_o
);

  // Full-precision product width and a sum width that can hold any
  // accumulator + product without losing the true result, so overflow is
  // detected even when the product is wider than the accumulator.
  localparam int PROD_W  = A_WIDTH + B_WIDTH;
  localparam int SUM_W   = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
  localparam int ACC_EXP = acc_exp(A_EXP, B_EXP);

  // Reject parameter sets that cannot describe a meaningful accumulator.
  if ((ACC_EXP != A_EXP + B_EXP) || (ACC_WIDTH < 2) || (LEN_WIDTH < 1)) begin : g_param_check
    $error("real_mac_acc: invalid parameter set");
  end

  state_t                      state_r;
  logic [LEN_WIDTH-1:0]        count_r;
  logic                        in_ready_r;
  logic                        out_valid_r;
  logic                        busy_r;

  logic signed [PROD_W-1:0]    prod_r;
  logic                        prod_vld_r;
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic                        ovf_r;

  logic                        xfer_s;
  logic                        start_fire_s;
  logic signed [PROD_W-1:0]    mult_s;
  logic signed [SUM_W-1:0]     sum_s;
  logic signed [ACC_WIDTH-1:0] wrap_s;
  logic                        add_ovf_s;

  // Handshake qualifiers, the multiplier and the exact-width adder.
  always_comb begin
    xfer_s       = 1'b0;
    start_fire_s = 1'b0;
    mult_s       = '0;
    sum_s        = '0;
    wrap_s       = '0;
    add_ovf_s    = 1'b0;

    xfer_s       = in_valid_i && in_ready_r;
    start_fire_s = (state_r == ST_IDLE) && start_i;
    mult_s       = PROD_W'(a_i) * PROD_W'(b_i);
    sum_s        = SUM_W'(acc_r) + SUM_W'(prod_r);
    wrap_s       = sum_s[ACC_WIDTH-1:0];
    // The sum overflowed if the wrapped value, re-extended, is not the true sum.
    if (sum_s != SUM_W'(wrap_s)) begin
      add_ovf_s = 1'b1;
    end else begin
      add_ovf_s = 1'b0;
    end
  end

  // Sequencer: state, product count and the registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= {LEN_WIDTH{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            busy_r <= 1'b1;
            if (len_i != {LEN_WIDTH{1'b0}}) begin
              count_r    <= len_i;
              state_r    <= ST_ACCUM;
              in_ready_r <= 1'b1;
            end else begin
              // Empty dot product: present the cleared accumulator at once.
              state_r     <= ST_OUT;
              out_valid_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (xfer_s) begin
            count_r <= count_r - LEN_WIDTH'(1);
            if (count_r == LEN_WIDTH'(1)) begin
              state_r    <= ST_DRAIN;
              in_ready_r <= 1'b0;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_ACCUM;
          end
        end
        ST_DRAIN: begin
          // The last product is being added this cycle.
          state_r     <= ST_OUT;
          out_valid_r <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready_i) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r <= ST_OUT;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          count_r     <= {LEN_WIDTH{1'b0}};
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the full-width product of each accepted operand pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r     <= '0;
      prod_vld_r <= 1'b0;
    end else begin
      prod_vld_r <= xfer_s;
      if (xfer_s) begin
        prod_r <= mult_s;
      end else begin
        prod_r <= prod_r;
      end
    end
  end

  // Stage 2: wrapping accumulate with a sticky overflow flag, cleared on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (start_fire_s) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (prod_vld_r) begin
      acc_r <= wrap_s;
      ovf_r <= ovf_r | add_ovf_s;
    end else begin
      acc_r <= acc_r;
      ovf_r <= ovf_r;
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign busy_o      = busy_r;
  assign acc_o       = acc_r;
  assign ovf_o       = ovf_r;

endmodule

// File: doc/real_mac_acc.md
REAL_MAC_ACC -- requirements
Module: real_mac_acc

Interface
REQ-001 Parameter A_WIDTH, default 16: width of signed fixed-point input a_i.
REQ-002 Parameter A_EXP, default -8: exponent of a_i (value = raw * 2^A_EXP).
REQ-003 Parameter B_WIDTH, default 17: width of signed fixed-point input b_i.
REQ-004 Parameter B_EXP, default -9: exponent of b_i.
REQ-005 Parameter ACC_WIDTH, default 40: accumulator width; accumulator exponent SHALL be A_EXP+B_EXP.
REQ-006 Parameter LEN_WIDTH, default 8: width of the product-count field.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  reset; asynchronous, active-high.
REQ-009 start_i  in  1  begin a new dot product; sampled only in IDLE.
REQ-010 len_i  in  LEN_WIDTH  number of products to accumulate; latched with start_i.
REQ-011 a_i  in  A_WIDTH signed  operand A, raw fixed-point.
REQ-012 b_i  in  B_WIDTH signed  operand B, raw fixed-point.
REQ-013 in_valid_i / in_ready_o  in / out  1 each  input handshake; transfer when both high.
REQ-014 acc_o  out  ACC_WIDTH signed  result, exponent A_EXP+B_EXP.
REQ-015 out_valid_o / out_ready_i  out / in  1 each  output handshake.
REQ-016 ovf_o  out  1  sticky accumulator-overflow flag for the current result.
REQ-017 busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, ACCUM, DRAIN, OUT.
REQ-019 IDLE: in_ready_o=0, out_valid_o=0; on start_i with len_i!=0, latch count, clear acc and ovf, go to ACCUM.
REQ-020 IDLE, start_i with len_i==0: clear acc and ovf, go directly to OUT on the next cycle.
REQ-021 ACCUM: in_ready_o=1; each transfer registers the full-width product a_i*b_i (A_WIDTH+B_WIDTH bits) in stage 1 and decrements the count.
REQ-022 Stage 2: a registered stage-1 product is sign-extended to ACC_WIDTH and added to acc in the cycle after its transfer.
REQ-023 On the transfer that brings the count to 0, go to DRAIN; in_ready_o=0 in DRAIN.
REQ-024 DRAIN lasts exactly one cycle (final add), then OUT; out_valid_o rises 2 cycles after the last input transfer.
REQ-025 Gaps in in_valid_i SHALL NOT add products or change the count; throughput is 1 product/cycle.
REQ-026 OUT: out_valid_o=1; acc_o and ovf_o held stable until out_ready_i; on the handshake, go to IDLE.
REQ-027 start_i is ignored outside IDLE; a start_i coinciding with the OUT handshake is ignored.
REQ-028 The accumulator wraps two's-complement; ovf_o sets when an add yields signed overflow and stays set until the next start.
REQ-029 acc_o always reflects the accumulator register; it is meaningful only while out_valid_o=1.

Reset
REQ-030 On rst: state=IDLE; acc_o=0, ovf_o=0, out_valid_o=0, in_ready_o=0, busy_o=0; count and stage-1 register cleared.
REQ-031 Reset mid-operation discards the partial sum; no out_valid_o pulse occurs for the aborted run.

Structure
REQ-032 Package real_mac_pkg holds the state enum and the function deriving the accumulator exponent from A_EXP and B_EXP.
REQ-033 Single module; no sub-module; the product register and accumulator are inline pipeline stages.

Verification
REQ-034 a_i=384 (1.5), b_i=1024 (2.0), len_i=4, in_valid_i held high -> acc_o=1572864 (12.0), ovf_o=0, out_valid_o 2 cycles after the 4th transfer.
REQ-035 len_i=0 -> out_valid_o=1 one cycle after start, acc_o=0; in_ready_o never rises.
REQ-036 len_i=3, in_valid_i high every other cycle, a_i=-256 (-1.0), b_i=512 (1.0) -> exactly 3 transfers, acc_o=-393216 (-3.0).
REQ-037 ACC_WIDTH=32, a_i=-32768 (-128.0), b_i=-65536 (-128.0), len_i=1 -> ovf_o=1, acc_o=-2^31; out_ready_i held low 5 cycles -> outputs stable throughout.
REQ-038 rst asserted asynchronously after 2 of 4 transfers -> all outputs 0 immediately; a following len_i=1 run with a_i=256, b_i=512 gives acc_o=131072 (1.0).
